// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : control_pipe
// Description : RV32I decode stage with a one-entry registered decode->execute
//               pipeline slot, valid/ready handshake, load-use hazard bubbling,
//               flush, illegal-instruction flagging and a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module control_pipe #(
  parameter int XLEN  = 32,
  parameter int FC_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FC_W-1:0]  fc,
  output logic             imm_mux,
  output logic             wreg,
  output logic             wmem,
  output logic             rmem,
  output logic             branch,
  output logic             jump,
  output logic [2:0]       mem_size,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] ill_cnt
);

  // Opcodes
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;

  // ALU function codes (4-bit core, zero-extended to FC_W)
  localparam logic [3:0] c_fc_add  = 4'd0;
  localparam logic [3:0] c_fc_sub  = 4'd1;
  localparam logic [3:0] c_fc_and  = 4'd2;
  localparam logic [3:0] c_fc_or   = 4'd3;
  localparam logic [3:0] c_fc_xor  = 4'd4;
  localparam logic [3:0] c_fc_sll  = 4'd5;
  localparam logic [3:0] c_fc_srl  = 4'd6;
  localparam logic [3:0] c_fc_sra  = 4'd7;
  localparam logic [3:0] c_fc_slt  = 4'd8;
  localparam logic [3:0] c_fc_sltu = 4'd9;

  localparam logic [6:0] c_f7_zero = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  // Base ALU mapping from funct3 (funct7=0 flavour)
  function automatic logic [3:0] alu_fc(input logic [2:0] f3);
    logic [3:0] v;
    case (f3)
      3'b000:  v = c_fc_add;
      3'b001:  v = c_fc_sll;
      3'b010:  v = c_fc_slt;
      3'b011:  v = c_fc_sltu;
      3'b100:  v = c_fc_xor;
      3'b101:  v = c_fc_srl;
      3'b110:  v = c_fc_or;
      default: v = c_fc_and;
    endcase
    return v;
  endfunction

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd_raw;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  assign w_opcode = instr[6:0];
  assign w_rd_raw = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_funct7 = instr[31:25];

  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;

  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign w_imm_u = {instr[31:12], 12'b0};

  logic [3:0]  w_dec_fc;
  logic        w_dec_imm_mux, w_dec_wreg, w_dec_wmem, w_dec_rmem;
  logic        w_dec_branch, w_dec_jump, w_legal;
  logic [2:0]  w_dec_mem_size;
  logic [31:0] w_dec_imm32;
  logic        w_use_rs1, w_use_rs2;

  // Raw per-opcode decode; legality is resolved afterwards
  always_comb begin
    w_dec_fc       = c_fc_add;
    w_dec_imm_mux  = 1'b0;
    w_dec_wreg     = 1'b0;
    w_dec_wmem     = 1'b0;
    w_dec_rmem     = 1'b0;
    w_dec_branch   = 1'b0;
    w_dec_jump     = 1'b0;
    w_dec_mem_size = 3'b000;
    w_dec_imm32    = 32'd0;
    w_legal        = 1'b1;
    w_use_rs1      = 1'b0;
    w_use_rs2      = 1'b0;
    case (w_opcode)
      c_opc_op: begin
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
        w_dec_wreg = 1'b1;
        if (w_funct7 == c_f7_zero)
          w_dec_fc = alu_fc(w_funct3);
        else if (w_funct7 == c_f7_alt && w_funct3 == 3'b000)
          w_dec_fc = c_fc_sub;
        else if (w_funct7 == c_f7_alt && w_funct3 == 3'b101)
          w_dec_fc = c_fc_sra;
        else
          w_legal = 1'b0;
      end
      c_opc_op_imm: begin
        w_use_rs1     = 1'b1;
        w_dec_wreg    = 1'b1;
        w_dec_imm_mux = 1'b1;
        w_dec_imm32   = w_imm_i;
        w_dec_fc      = alu_fc(w_funct3);
        // Only the shift forms carry a funct7 field in the immediate
        if (w_funct3 == 3'b001 && w_funct7 != c_f7_zero)
          w_legal = 1'b0;
        if (w_funct3 == 3'b101) begin
          if (w_funct7 == c_f7_alt)
            w_dec_fc = c_fc_sra;
          else if (w_funct7 != c_f7_zero)
            w_legal = 1'b0;
        end
      end
      c_opc_load: begin
        w_use_rs1      = 1'b1;
        w_dec_rmem     = 1'b1;
        w_dec_wreg     = 1'b1;
        w_dec_imm_mux  = 1'b1;
        w_dec_mem_size = w_funct3;
        w_dec_imm32    = w_imm_i;
        if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111)
          w_legal = 1'b0;
      end
      c_opc_store: begin
        w_use_rs1      = 1'b1;
        w_use_rs2      = 1'b1;
        w_dec_wmem     = 1'b1;
        w_dec_imm_mux  = 1'b1;
        w_dec_mem_size = w_funct3;
        w_dec_imm32    = w_imm_s;
        if (w_funct3 > 3'b010)
          w_legal = 1'b0;
      end
      c_opc_branch: begin
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        w_dec_branch = 1'b1;
        w_dec_imm32  = w_imm_b;
        case (w_funct3[2:1])
          2'b00:   w_dec_fc = c_fc_sub;
          2'b10:   w_dec_fc = c_fc_slt;
          2'b11:   w_dec_fc = c_fc_sltu;
          default: w_legal  = 1'b0;
        endcase
      end
      c_opc_jal: begin
        w_dec_wreg    = 1'b1;
        w_dec_jump    = 1'b1;
        w_dec_imm_mux = 1'b1;
        w_dec_imm32   = w_imm_j;
      end
      c_opc_jalr: begin
        w_use_rs1     = 1'b1;
        w_dec_wreg    = 1'b1;
        w_dec_jump    = 1'b1;
        w_dec_imm_mux = 1'b1;
        w_dec_imm32   = w_imm_i;
        if (w_funct3 != 3'b000)
          w_legal = 1'b0;
      end
      c_opc_lui, c_opc_auipc: begin
        w_dec_wreg    = 1'b1;
        w_dec_imm_mux = 1'b1;
        w_dec_imm32   = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Final bundle: an illegal instruction carries no side-effecting enables
  logic [FC_W-1:0] w_fc;
  logic            w_imm_mux, w_wreg, w_wmem, w_rmem, w_branch, w_jump;
  logic [2:0]      w_mem_size;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm;

  assign w_fc       = w_legal ? FC_W'(w_dec_fc) : '0;
  assign w_imm_mux  = w_legal & w_dec_imm_mux;
  assign w_wreg     = w_legal & w_dec_wreg;
  assign w_wmem     = w_legal & w_dec_wmem;
  assign w_rmem     = w_legal & w_dec_rmem;
  assign w_branch   = w_legal & w_dec_branch;
  assign w_jump     = w_legal & w_dec_jump;
  assign w_mem_size = w_legal ? w_dec_mem_size : 3'b000;
  assign w_rd       = w_wreg ? w_rd_raw : 5'd0;
  // XLEN >= 32, so at least one copy of bit 31 is prepended
  assign w_imm      = w_legal ? {{(XLEN-31){w_dec_imm32[31]}}, w_dec_imm32[30:0]} : '0;

  logic            r_out_valid;
  logic [FC_W-1:0] r_fc;
  logic            r_imm_mux, r_wreg, r_wmem, r_rmem, r_branch, r_jump, r_illegal;
  logic [2:0]      r_mem_size;
  logic [4:0]      r_rd, r_rs1, r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [CNT_W-1:0] r_ill_cnt;

  logic w_haz;
  logic w_accept;

  // A held load whose destination is read by the incoming instruction stalls it
  assign w_haz = r_out_valid && r_rmem && (r_rd != 5'd0) && in_valid &&
                 ((w_use_rs1 && (w_rs1 == r_rd)) || (w_use_rs2 && (w_rs2 == r_rd)));

  assign in_ready = !flush && !w_haz && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Pipeline slot: flush kills, accept loads, consume-without-refill drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_fc        <= '0;
      r_imm_mux   <= 1'b0;
      r_wreg      <= 1'b0;
      r_wmem      <= 1'b0;
      r_rmem      <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
      r_mem_size  <= 3'b000;
      r_rd        <= 5'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_imm       <= '0;
      r_ill_cnt   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_fc        <= w_fc;
      r_imm_mux   <= w_imm_mux;
      r_wreg      <= w_wreg;
      r_wmem      <= w_wmem;
      r_rmem      <= w_rmem;
      r_branch    <= w_branch;
      r_jump      <= w_jump;
      r_illegal   <= !w_legal;
      r_mem_size  <= w_mem_size;
      r_rd        <= w_rd;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_imm       <= w_imm;
      if (!w_legal && (r_ill_cnt != {CNT_W{1'b1}}))
        r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign fc        = r_fc;
  assign imm_mux   = r_imm_mux;
  assign wreg      = r_wreg;
  assign wmem      = r_wmem;
  assign rmem      = r_rmem;
  assign branch    = r_branch;
  assign jump      = r_jump;
  assign mem_size  = r_mem_size;
  assign rd        = r_rd;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign imm       = r_imm;
  assign illegal   = r_illegal;
  assign ill_cnt   = r_ill_cnt;

endmodule
`default_nettype wire
